// File: rtl/noc_merge2_rr.sv
// 2:1 round-robin merge with per-side FIFOs, a registered output stage and
// saturating per-side delivery counters, for the upward path of the routing tree.
module noc_merge2_rr #(
    parameter int WIDTH      = 9,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   PTR_ZERO = {(PTR_W + 1){1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [2][FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_r [2];
    logic [PTR_W:0]   rd_ptr_r [2];
    logic [WIDTH-1:0] in_data_s [2];
    logic [1:0]       in_valid_s;
    logic [1:0]       full_s;
    logic [1:0]       empty_s;
    logic [1:0]       push_s;
    logic [1:0]       pop_s;
    logic             grant_s;
    logic             load_s;
    logic             xfer_s;
    logic [WIDTH-1:0] head_s;
    logic             last_grant_r;
    logic             out_valid_r;
    logic             out_src_r;
    logic [WIDTH-1:0] out_data_r;
    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;

    assign in_valid_s   = {in1_valid, in0_valid};
    assign in_data_s[0] = in0_data;
    assign in_data_s[1] = in1_data;

    // FIFO status; the extra pointer bit separates full from empty
    always_comb begin
        empty_s = 2'b00;
        full_s  = 2'b00;
        push_s  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            empty_s[i] = (wr_ptr_r[i] == rd_ptr_r[i]);
            full_s[i]  = (wr_ptr_r[i][PTR_W] != rd_ptr_r[i][PTR_W]) &&
                         (wr_ptr_r[i][PTR_W-1:0] == rd_ptr_r[i][PTR_W-1:0]);
            push_s[i]  = in_valid_s[i] && !full_s[i];
        end
    end

    // Round-robin grant and output-stage load decision
    always_comb begin
        grant_s = 1'b0;
        if (!empty_s[0] && !empty_s[1]) begin
            grant_s = ~last_grant_r;
        end else if (!empty_s[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        load_s = (!out_valid_r || out_ready) && (empty_s != 2'b11);
        xfer_s = out_valid_r && out_ready;
        pop_s  = 2'b00;
        if (load_s) begin
            pop_s[grant_s] = 1'b1;
        end else begin
            pop_s = 2'b00;
        end
        head_s = mem_r[grant_s][rd_ptr_r[grant_s][PTR_W-1:0]];
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_r[i] <= PTR_ZERO;
                rd_ptr_r[i] <= PTR_ZERO;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + PTR_ONE;
                if (pop_s[i])  rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
            end
        end
    end

    // FIFO storage; contents are meaningless once the pointers reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push_s[i]) mem_r[i][wr_ptr_r[i][PTR_W-1:0]] <= in_data_s[i];
        end
    end

    // Output register and arbitration history
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {WIDTH{1'b0}};
            out_src_r    <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (load_s) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= head_s;
            out_src_r    <= grant_s;
            last_grant_r <= grant_s;
        end else if (xfer_s) begin
            out_valid_r  <= 1'b0;
        end
    end

    // Saturating per-side delivery counters
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (xfer_s && !out_src_r && (cnt0_r != CNT_MAX)) cnt0_r <= cnt0_r + CNT_ONE;
            if (xfer_s && out_src_r && (cnt1_r != CNT_MAX))  cnt1_r <= cnt1_r + CNT_ONE;
        end
    end

    assign in0_ready = ~full_s[0];
    assign in1_ready = ~full_s[1];
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;
    assign cnt0      = cnt0_r;
    assign cnt1      = cnt1_r;

endmodule
